// File: rtl/accumulator_32bits.sv
// Streaming operand accumulator with a sticky carry-out flag and valid/ready ports.
// Define ACC_SATURATE_EN to clamp the sum to all-ones after the first carry.
module accumulator_32bits #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             fire;
  logic             last;
  logic             take;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc_add;

  assign fire = in_valid & in_ready;
  assign last = (cnt == CNT_W'(1));
  assign take = (state == IDLE) & start;

  // Explicit ripple chain so the sum matches the downstream adder bit for bit.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign sum[i] = acc[i] ^ in_data[i] ^ carry[i];
    assign carry[i+1] = (acc[i] & in_data[i])
                      | (carry[i] & (acc[i] ^ in_data[i]));
  end

`ifdef ACC_SATURATE_EN
  assign acc_add = (carry[WIDTH] | ovf) ? {WIDTH{1'b1}} : sum;
`else
  assign acc_add = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (fire && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= '0;
      cnt <= len;
      ovf <= 1'b0;
    end else if (fire) begin
      acc <= acc_add;
      cnt <= cnt - CNT_W'(1);
      ovf <= ovf | carry[WIDTH];
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = out_valid ? acc : '0;
  assign out_cout  = out_valid & ovf;

endmodule
